// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream adapter: default word width,
// output-buffer state encoding and head-register load selection.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // Buffer occupancy states; the encoding doubles as the stored-entry count.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  // What the head register loads on the next edge.
  typedef enum logic [1:0] {
    HEAD_HOLD       = 2'd0,
    HEAD_LOAD_RDATA = 2'd1,
    HEAD_LOAD_TAIL  = 2'd2
  } head_sel_t;

  // Number of stored entries for a given buffer state.
  function automatic logic [1:0] state_level(input state_t s);
    case (s)
      S1:      return 2'd1;
      S2:      return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Signal bundle between the FIFO read port, the stream adapter and the
// stream consumer. The adapter uses the master view; its environment
// (read-pointer stage, memory and consumer) uses the slave view.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  r_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [1:0]            level;
  logic                  err;

  modport master (
    input  empty,
    input  rdata,
    input  m_ready,
    output r_en,
    output m_valid,
    output m_data,
    output level,
    output err
  );

  modport slave (
    output empty,
    output rdata,
    output m_ready,
    input  r_en,
    input  m_valid,
    input  m_data,
    input  level,
    input  err
  );

endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer: head is the word presented on the stream, tail
// holds the second word when the consumer stalls. The state machine in the
// parent decides when head loads from memory data or from tail, and when
// tail captures memory data.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  head_sel_t             head_sel,
  input  logic                  tail_load,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] head_reg;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] tail_reg;

  // Select the next head value; holding is the default so data stays stable.
  always_comb begin
    head_next = head_reg;
    case (head_sel)
      HEAD_LOAD_RDATA: head_next = rdata;
      HEAD_LOAD_TAIL:  head_next = tail_reg;
      default:         head_next = head_reg;
    endcase
  end

  // Head register; cleared on reset so the stream data reads zero.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      head_reg <= '0;
    end else begin
      head_reg <= head_next;
    end
  end

  // Tail register captures memory data only when the head is occupied.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      tail_reg <= '0;
    end else if (tail_load) begin
      tail_reg <= rdata;
    end
  end

  assign head = head_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port to valid/ready stream adapter. The memory returns data one
// cycle after a read is issued, so a read is only requested when the buffer
// is guaranteed to have room for it once it lands: stored entries plus the
// word already in flight, minus the word leaving this cycle, must be below 2.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic              rclk,
  input logic              rrst,
  fifo_rd_stream_if.master bus
);

  state_t    state_reg;
  state_t    state_next;
  logic      inflight_reg;
  logic      err_reg;
  logic      err_next;
  logic      pop;
  logic      push;
  logic      read_issue;
  logic [2:0] occupancy;
  head_sel_t head_sel;
  logic      tail_load;

  assign bus.level   = state_level(state_reg);
  assign bus.m_valid = (state_reg != S0);
  assign bus.err     = err_reg;

  assign pop  = bus.m_valid & bus.m_ready;
  assign push = inflight_reg;

  // Entries the buffer will hold after this edge if no new read is issued.
  assign occupancy = {1'b0, bus.level} + {2'b00, inflight_reg} - {2'b00, pop};

  // Reset gates the request directly so it drops without waiting for a clock.
  assign bus.r_en   = ~bus.empty & ~rrst & (occupancy < 3'd2);
  assign read_issue = bus.r_en & ~bus.empty;

  // In-flight flag: memory data is valid exactly one cycle after a read.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= read_issue;
    end
  end

  // Buffer state and sticky overflow flag.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_reg <= S0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
    end
  end

  // Next state and buffer controls from the push/pop combination.
  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    head_sel   = HEAD_HOLD;
    tail_load  = 1'b0;
    case (state_reg)
      S0: begin
        if (push) begin
          head_sel   = HEAD_LOAD_RDATA;
          state_next = S1;
        end
      end
      S1: begin
        if (push && !pop) begin
          tail_load  = 1'b1;
          state_next = S2;
        end else if (push && pop) begin
          head_sel   = HEAD_LOAD_RDATA;
        end else if (!push && pop) begin
          state_next = S0;
        end
      end
      S2: begin
        if (pop && !push) begin
          head_sel   = HEAD_LOAD_TAIL;
          state_next = S1;
        end else if (pop && push) begin
          head_sel   = HEAD_LOAD_TAIL;
          tail_load  = 1'b1;
        end else if (push) begin
          // No room: the arriving word is dropped and the error latches.
          err_next   = 1'b1;
        end
      end
      default: begin
        state_next = S0;
      end
    endcase
  end

  fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .rclk      (rclk),
    .rrst      (rrst),
    .head_sel  (head_sel),
    .tail_load (tail_load),
    .rdata     (bus.rdata),
    .head      (bus.m_data)
  );

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the FIFO word.
REQ-002 rclk  input  1  read-domain clock; all state SHALL update on its rising edge.
REQ-003 rrst  input  1  reset, asynchronous, active-high; one clock; no other clock or reset.
REQ-004 empty  input  1  registered empty flag from the read-pointer stage.
REQ-005 rdata  input  DATA_WIDTH  memory read data, valid the cycle after a cycle with r_en=1 and empty=0.
REQ-006 r_en  output  1  read request to the read-pointer stage and the memory.
REQ-007 m_valid  output  1  stream data valid.
REQ-008 m_ready  input  1  stream consumer ready.
REQ-009 m_data  output  DATA_WIDTH  stream data, equal to the head entry.
REQ-010 level  output  2  stored entries, 0..2.
REQ-011 err  output  1  sticky overflow error.

Function
REQ-012 The block SHALL convert the FIFO read port (read-then-data, 1-cycle latency) into a valid/ready stream with a 2-entry buffer (head, tail).
REQ-013 A read is issued in a cycle iff r_en=1 and empty=0; the in-flight flag SHALL be set for exactly the next cycle.
REQ-014 pop = m_valid & m_ready; push = in-flight flag (rdata captured that cycle).
REQ-015 r_en SHALL equal !empty & !rrst & (level + inflight - pop < 2); combinational path from m_ready to r_en allowed.
REQ-016 States: S0 (level 0), S1 (level 1), S2 (level 2); m_valid = (state != S0), registered-state derived.
REQ-017 S0: push -> head<=rdata, S1; else stay.
REQ-018 S1: push & !pop -> tail<=rdata, S2; push & pop -> head<=rdata, S1; !push & pop -> S0; else stay.
REQ-019 S2: pop & !push -> head<=tail, S1; pop & push -> head<=tail, tail<=rdata, S2; no pop -> stay, head/tail held.
REQ-020 push in S2 without pop SHALL set err=1 (sticky until reset) and discard rdata; unreachable when REQ-015 holds.
REQ-021 m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-022 Throughput: with empty=0 continuously and m_ready=1, one word per cycle after a 2-cycle startup latency (r_en cycle 0, m_valid cycle 2? no: push cycle 1, m_valid cycle 2).
REQ-023 Order SHALL be strictly FIFO; no word duplicated or dropped except per REQ-020.
REQ-024 empty rising while a read is in flight SHALL not cancel that push.

Reset
REQ-025 On rrst=1: state S0, level=0, inflight=0, m_valid=0, m_data=0, err=0, r_en=0, immediately and independent of rclk.
REQ-026 Reset mid-operation SHALL discard stored and in-flight words; the top level drives the read-pointer stage reset as ~rrst so both reset together.
REQ-027 First r_en possible in the first rclk cycle after rrst deasserts.

Structure
REQ-028 Shared package fifo_pkg SHALL hold DATA_WIDTH default and the state enum (S0, S1, S2).
REQ-029 One sub-module is natural: fifo_out_buf (head/tail registers with load/shift controls); state machine and r_en logic stay in fifo_rd_stream.

Verification
REQ-030 Reset with empty=0: r_en=0, m_valid=0, level=0 while rrst=1; r_en=1 first cycle after release.
REQ-031 empty=0 for 4 cycles supplying 0x11,0x22,0x33,0x44, m_ready=1 -> m_data 0x11..0x44 on 4 consecutive cycles, level never 2.
REQ-032 Same stream, m_ready=0 -> exactly 2 reads issued, level=2, m_data=0x11 held, r_en=0; m_ready=1 -> 0x11,0x22,0x33,0x44 in order, no gaps after restart.
REQ-033 Single word 0xA5 then empty=1 -> m_valid 1 cycle after push, drops after pop, r_en stays 0.
REQ-034 Force push in S2 without pop -> err=1 held, m_data unchanged.
REQ-035 rrst pulse with level=2 and read in flight -> level=0, m_valid=0 same cycle, in-flight word never appears.
